cga_mic_stack_ctrl: RTL and testbench
=====================================

CGA_MIC_STACK_CTRL -- requirements
Module: cga_mic_stack_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_MAX, default 4, meaning the number of physical stack levels in each bit slice.
REQ-002 SHALL have port MCLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port RST, input, 1 bit: synchronous reset, active-high.
REQ-004 SHALL have port CMD, input, 2 bits: stack command, encoded 00 NOP, 01 PUSH, 10 POP, 11 FLUSH.
REQ-005 SHALL have port CMD_VALID, input, 1 bit: CMD is presented this cycle.
REQ-006 SHALL have port HOLD, input, 1 bit: microsequencer stall; no command is accepted while high.
REQ-007 SHALL have port ERR_CLR, input, 1 bit: clears the sticky error flags.
REQ-008 SHALL have port CMD_READY, output, 1 bit: equal to NOT HOLD; a command is accepted when CMD_VALID AND CMD_READY.
REQ-009 SHALL have ports S3, S3N, S4S3N, S4NS3N, LOAD, output, 1 bit each: registered slice-mode controls.
REQ-010 SHALL have port SCLK_EN, output, 1 bit: enables the slice shift clock for exactly one cycle per effective operation.
REQ-011 SHALL have port DEPTH, output, 3 bits: current number of valid entries.
REQ-012 SHALL have ports EMPTY, FULL, OVF, UNF, output, 1 bit each: EMPTY means DEPTH=0; FULL means DEPTH=DEPTH_MAX; OVF and UNF are the sticky overflow and underflow flags.

Function
REQ-013 SHALL register all control outputs, so that they are valid in the cycle after acceptance (latency 1).
REQ-014 SHALL drive, for an accepted PUSH, S3=0, S3N=1, S4S3N=1, S4NS3N=0, LOAD=1 and SCLK_EN=1, and SHALL increment DEPTH.
REQ-015 SHALL drive, for an accepted POP with DEPTH>0, S3=1, S3N=0, S4S3N=0, S4NS3N=0, LOAD=1 and SCLK_EN=1, and SHALL decrement DEPTH.
REQ-016 SHALL drive, for NOP, no accepted command, or HOLD, S3=0, S3N=1, S4S3N=0, S4NS3N=1, LOAD=0 and SCLK_EN=0 (recirculate/hold); DEPTH is unchanged.
REQ-017 SHALL, for an accepted FLUSH, set DEPTH to 0 next cycle with SCLK_EN=0 and the hold controls; slice contents are not cleared.
REQ-018 SHALL, for PUSH at FULL, perform the push (bottom entry lost), keep DEPTH at DEPTH_MAX, and set OVF.
REQ-019 SHALL, for POP at EMPTY, drive the hold controls with SCLK_EN=0, keep DEPTH at 0, and set UNF.
REQ-020 SHALL clear OVF and UNF on ERR_CLR; a new error in the same cycle wins, and the flag reads 1.
REQ-021 SHALL keep the S3N/S3 and S4S3N/S4NS3N pairs mutually consistent, so that S4S3N and S4NS3N are never both 1.
REQ-022 SHALL never let DEPTH exceed DEPTH_MAX or wrap below 0.

Reset
REQ-023 SHALL, with RST high at the MCLK edge, force DEPTH=0, OVF=0, UNF=0, SCLK_EN=0, LOAD=0, S3=0, S3N=1, S4S3N=0 and S4NS3N=1.
REQ-024 SHALL give RST priority over any command in the same cycle, including mid-sequence; the first command after RST deasserts is accepted normally.

Structure
REQ-025 SHALL take the CMD encodings, DEPTH_MAX default and DEPTH width from a shared package, cga_mic_stack_pkg.
REQ-026 SHALL place depth tracking in one sub-module, cga_mic_stack_depth, holding the saturating counter with OVF/UNF generation; decode and output registers stay in the top module.

Verification
REQ-027 SHALL cover: reset, then PUSH x3 -> DEPTH 1,2,3 in successive cycles; each PUSH yields S4S3N=1, LOAD=1, SCLK_EN=1 one cycle later.
REQ-028 SHALL cover: PUSH x5 from empty -> DEPTH saturates at 4, FULL=1, OVF=1 after the 5th push, SCLK_EN=1 on all 5.
REQ-029 SHALL cover: POP from empty -> SCLK_EN=0, DEPTH=0, UNF=1; ERR_CLR next cycle -> UNF=0.
REQ-030 SHALL cover: HOLD=1 with CMD_VALID=1 PUSH for 3 cycles -> CMD_READY=0, DEPTH unchanged, hold controls; HOLD drop -> push accepted.
REQ-031 SHALL cover: DEPTH=3, then FLUSH -> DEPTH=0, EMPTY=1, SCLK_EN=0; RST asserted with PUSH -> all reset values.
REQ-032 SHALL cover: POP at FULL with ERR_CLR high and OVF=1 -> OVF=0, DEPTH=3, S3=1.

Source files
------------

// File: rtl/cga_mic_stack_pkg.sv
// Shared definitions for the microprogram stack controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: command encodings, depth width and default depth, slice-control
// bundle type and the three slice-control patterns (hold, push, pop).
package cga_mic_stack_pkg;

  localparam int DEPTH_W       = 3;
  localparam int DEPTH_MAX_DEF = 4;

  typedef enum logic [1:0] {
    CMD_NOP   = 2'b00,
    CMD_PUSH  = 2'b01,
    CMD_POP   = 2'b10,
    CMD_FLUSH = 2'b11
  } cmd_e;

  // Slice-mode controls, registered together in the top module.
  typedef struct packed {
    logic s3;
    logic s3n;
    logic s4s3n;
    logic s4ns3n;
    logic load;
    logic sclk_en;
  } ctrl_t;

  // Recirculate: slices keep their contents, no shift clock.
  localparam ctrl_t CTRL_HOLD = '{s3: 1'b0, s3n: 1'b1, s4s3n: 1'b0, s4ns3n: 1'b1,
                                  load: 1'b0, sclk_en: 1'b0};
  // Shift down one level and load the new top entry.
  localparam ctrl_t CTRL_PUSH = '{s3: 1'b0, s3n: 1'b1, s4s3n: 1'b1, s4ns3n: 1'b0,
                                  load: 1'b1, sclk_en: 1'b1};
  // Shift up one level, exposing the next entry on top.
  localparam ctrl_t CTRL_POP  = '{s3: 1'b1, s3n: 1'b0, s4s3n: 1'b0, s4ns3n: 1'b0,
                                  load: 1'b1, sclk_en: 1'b1};

endpackage

// File: rtl/cga_mic_stack_depth.sv
// Saturating stack-depth counter with sticky overflow/underflow flags.
// Latency: 1 cycle from accepted operation pulse to updated depth/flags.
// Backpressure: none; the caller presents only accepted, mutually exclusive pulses.
// Ports: clk, rst (sync, active-high); push/pop/flush accepted-op pulses;
//   err_clr clears flags; depth, empty, full, ovf, unf outputs.
module cga_mic_stack_depth
  import cga_mic_stack_pkg::*;
#(
  parameter int DEPTH_MAX = DEPTH_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic               err_clr,
  output logic [DEPTH_W-1:0] depth,
  output logic               empty,
  output logic               full,
  output logic               ovf,
  output logic               unf
);

  localparam logic [DEPTH_W-1:0] DMAX = DEPTH_W'(DEPTH_MAX);

  always_comb begin
    empty = (depth == '0);
    full  = (depth == DMAX);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
    end else begin
      // A push at full still shifts the slices (bottom entry lost) but the
      // count saturates; a pop at empty leaves the count at zero.
      if (flush)
        depth <= '0;
      else if (push && !full)
        depth <= depth + 1'b1;
      else if (pop && !empty)
        depth <= depth - 1'b1;

      // New error in the same cycle as a clear wins.
      ovf <= (push && full)  || (ovf && !err_clr);
      unf <= (pop  && empty) || (unf && !err_clr);
    end
  end

endmodule

// File: rtl/cga_mic_stack_ctrl.sv
// Microprogram stack controller: decodes stack commands into bit-slice mode controls.
// Latency: 1 cycle from command acceptance to registered controls and depth.
// Backpressure: CMD_READY = !HOLD; commands are accepted only on CMD_VALID && CMD_READY.
// Ports: MCLK, RST (sync, active-high); CMD/CMD_VALID/HOLD/ERR_CLR inputs;
//   CMD_READY; S3, S3N, S4S3N, S4NS3N, LOAD, SCLK_EN slice controls;
//   DEPTH, EMPTY, FULL, OVF, UNF status.
module cga_mic_stack_ctrl
  import cga_mic_stack_pkg::*;
#(
  parameter int DEPTH_MAX = DEPTH_MAX_DEF
) (
  input  logic               MCLK,
  input  logic               RST,
  input  logic [1:0]         CMD,
  input  logic               CMD_VALID,
  input  logic               HOLD,
  input  logic               ERR_CLR,
  output logic               CMD_READY,
  output logic               S3,
  output logic               S3N,
  output logic               S4S3N,
  output logic               S4NS3N,
  output logic               LOAD,
  output logic               SCLK_EN,
  output logic [DEPTH_W-1:0] DEPTH,
  output logic               EMPTY,
  output logic               FULL,
  output logic               OVF,
  output logic               UNF
);

  logic  accept;
  cmd_e  cmd;
  logic  push_acc;
  logic  pop_acc;
  logic  flush_acc;
  ctrl_t ctrl_nxt;
  ctrl_t ctrl_q;

  assign CMD_READY = !HOLD;
  assign accept    = CMD_VALID && !HOLD;
  assign cmd       = cmd_e'(CMD);

  always_comb begin
    ctrl_nxt  = CTRL_HOLD;
    push_acc  = 1'b0;
    pop_acc   = 1'b0;
    flush_acc = 1'b0;
    if (accept) begin
      case (cmd)
        CMD_PUSH: begin
          push_acc = 1'b1;
          ctrl_nxt = CTRL_PUSH;
        end
        CMD_POP: begin
          pop_acc = 1'b1;
          // Popping an empty stack must not disturb the slices.
          if (!EMPTY)
            ctrl_nxt = CTRL_POP;
        end
        CMD_FLUSH: flush_acc = 1'b1;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge MCLK) begin
    if (RST)
      ctrl_q <= CTRL_HOLD;
    else
      ctrl_q <= ctrl_nxt;
  end

  assign S3      = ctrl_q.s3;
  assign S3N     = ctrl_q.s3n;
  assign S4S3N   = ctrl_q.s4s3n;
  assign S4NS3N  = ctrl_q.s4ns3n;
  assign LOAD    = ctrl_q.load;
  assign SCLK_EN = ctrl_q.sclk_en;

  cga_mic_stack_depth #(
    .DEPTH_MAX(DEPTH_MAX)
  ) u_depth (
    .clk    (MCLK),
    .rst    (RST),
    .push   (push_acc),
    .pop    (pop_acc),
    .flush  (flush_acc),
    .err_clr(ERR_CLR),
    .depth  (DEPTH),
    .empty  (EMPTY),
    .full   (FULL),
    .ovf    (OVF),
    .unf    (UNF)
  );

endmodule

// File: tb/tb_cga_mic_stack_ctrl.sv
// Directed bench for cga_mic_stack_ctrl: vector table plus a pop-down sequence.
module tb_cga_mic_stack_ctrl;

  localparam logic [1:0] NOP = 2'b00, PSH = 2'b01, POP = 2'b10, FLS = 2'b11;
  localparam int K_HOLD = 0, K_PUSH = 1, K_POP = 2;

  typedef struct packed {
    logic [2:0] depth;
    logic s3, s3n, s4s3n, s4ns3n, load, sclk_en;
    logic empty, full, ovf, unf;
  } obs_t;

  typedef struct {
    logic       rst;
    logic [1:0] cmd;
    logic       vld;
    logic       hold;
    logic       eclr;
    obs_t       exp;
  } vec_t;

  logic       MCLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] CMD = 2'b00;
  logic       CMD_VALID = 1'b0;
  logic       HOLD = 1'b0;
  logic       ERR_CLR = 1'b0;
  logic       CMD_READY, S3, S3N, S4S3N, S4NS3N, LOAD, SCLK_EN;
  logic [2:0] DEPTH;
  logic       EMPTY, FULL, OVF, UNF;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  always #5 MCLK = ~MCLK;

  cga_mic_stack_ctrl #(.DEPTH_MAX(4)) dut (
    .MCLK(MCLK), .RST(RST), .CMD(CMD), .CMD_VALID(CMD_VALID), .HOLD(HOLD),
    .ERR_CLR(ERR_CLR), .CMD_READY(CMD_READY), .S3(S3), .S3N(S3N),
    .S4S3N(S4S3N), .S4NS3N(S4NS3N), .LOAD(LOAD), .SCLK_EN(SCLK_EN),
    .DEPTH(DEPTH), .EMPTY(EMPTY), .FULL(FULL), .OVF(OVF), .UNF(UNF)
  );

  // Expected observation after the clock edge: control pattern by kind,
  // EMPTY/FULL written out by hand alongside depth.
  function automatic obs_t mk_obs(int d, int kind, logic e, logic f, logic o, logic u);
    obs_t r;
    r.depth = 3'(d);
    case (kind)
      K_PUSH:  {r.s3, r.s3n, r.s4s3n, r.s4ns3n, r.load, r.sclk_en} = 6'b011011;
      K_POP:   {r.s3, r.s3n, r.s4s3n, r.s4ns3n, r.load, r.sclk_en} = 6'b100011;
      default: {r.s3, r.s3n, r.s4s3n, r.s4ns3n, r.load, r.sclk_en} = 6'b010100;
    endcase
    r.empty = e; r.full = f; r.ovf = o; r.unf = u;
    return r;
  endfunction

  task automatic add(logic rst, logic [1:0] cmd, logic vld, logic hold, logic eclr,
                     int d, int kind, logic e, logic f, logic o, logic u);
    vec_t v;
    v.rst = rst; v.cmd = cmd; v.vld = vld; v.hold = hold; v.eclr = eclr;
    v.exp = mk_obs(d, kind, e, f, o, u);
    tbl.push_back(v);
  endtask

  task automatic check(string name, obs_t exp);
    obs_t act;
    act = {DEPTH, S3, S3N, S4S3N, S4NS3N, LOAD, SCLK_EN, EMPTY, FULL, OVF, UNF};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got depth=%0d ctl=%b e/f/o/u=%b, expected depth=%0d ctl=%b e/f/o/u=%b",
               name, act.depth, act[9:4], act[3:0], exp.depth, exp[9:4], exp[3:0]);
    end
    checks++;
    if (S4S3N && S4NS3N) begin
      errors++;
      $display("FAIL %s_excl: got S4S3N=1 S4NS3N=1, expected not both 1", name);
    end
  endtask

  // Apply inputs on the falling edge, check ready combinationally, then the
  // registered outputs just after the next rising edge.
  task automatic apply(string name, logic rst, logic [1:0] cmd, logic vld,
                       logic hold, logic eclr, obs_t exp);
    @(negedge MCLK);
    RST = rst; CMD = cmd; CMD_VALID = vld; HOLD = hold; ERR_CLR = eclr;
    #1;
    checks++;
    if (CMD_READY !== !hold) begin
      errors++;
      $display("FAIL %s_ready: got %b expected %b", name, CMD_READY, !hold);
    end
    @(posedge MCLK);
    #1;
    check(name, exp);
  endtask

  initial begin
    //   rst cmd vld hold eclr  depth kind    E  F  O  U
    add(1, NOP, 0, 0, 0,   0, K_HOLD, 1, 0, 0, 0);  // reset
    add(0, PSH, 1, 0, 0,   1, K_PUSH, 0, 0, 0, 0);
    add(0, PSH, 1, 0, 0,   2, K_PUSH, 0, 0, 0, 0);
    add(0, PSH, 1, 0, 0,   3, K_PUSH, 0, 0, 0, 0);
    add(0, PSH, 1, 0, 0,   4, K_PUSH, 0, 1, 0, 0);
    add(0, PSH, 1, 0, 0,   4, K_PUSH, 0, 1, 1, 0);  // 5th push: saturate, OVF
    add(0, POP, 1, 0, 1,   3, K_POP,  0, 0, 0, 0);  // pop at full + clear
    add(0, NOP, 1, 0, 0,   3, K_HOLD, 0, 0, 0, 0);
    add(0, FLS, 1, 0, 0,   0, K_HOLD, 1, 0, 0, 0);  // flush from 3
    add(0, POP, 1, 0, 0,   0, K_HOLD, 1, 0, 0, 1);  // underflow
    add(0, NOP, 0, 0, 1,   0, K_HOLD, 1, 0, 0, 0);  // clear UNF
    add(0, PSH, 1, 1, 0,   0, K_HOLD, 1, 0, 0, 0);  // HOLD x3
    add(0, PSH, 1, 1, 0,   0, K_HOLD, 1, 0, 0, 0);
    add(0, PSH, 1, 1, 0,   0, K_HOLD, 1, 0, 0, 0);
    add(0, PSH, 1, 0, 0,   1, K_PUSH, 0, 0, 0, 0);  // HOLD dropped
    add(0, PSH, 0, 0, 0,   1, K_HOLD, 0, 0, 0, 0);  // not valid
    add(0, PSH, 1, 0, 0,   2, K_PUSH, 0, 0, 0, 0);
    add(1, PSH, 1, 0, 0,   0, K_HOLD, 1, 0, 0, 0);  // reset beats push
    add(0, PSH, 1, 0, 0,   1, K_PUSH, 0, 0, 0, 0);  // first after reset
    add(0, PSH, 1, 0, 0,   2, K_PUSH, 0, 0, 0, 0);
    add(0, PSH, 1, 0, 0,   3, K_PUSH, 0, 0, 0, 0);
    add(0, PSH, 1, 0, 0,   4, K_PUSH, 0, 1, 0, 0);
    add(0, PSH, 1, 0, 0,   4, K_PUSH, 0, 1, 1, 0);
    add(0, PSH, 1, 0, 1,   4, K_PUSH, 0, 1, 1, 0);  // new OVF beats clear
    add(0, NOP, 1, 0, 1,   4, K_HOLD, 0, 1, 0, 0);
    add(0, FLS, 1, 0, 0,   0, K_HOLD, 1, 0, 0, 0);
    add(0, POP, 1, 0, 0,   0, K_HOLD, 1, 0, 0, 1);
    add(0, POP, 1, 0, 1,   0, K_HOLD, 1, 0, 0, 1);  // new UNF beats clear
    add(0, POP, 1, 1, 0,   0, K_HOLD, 1, 0, 0, 1);  // pop under HOLD: no effect

    foreach (tbl[i])
      apply($sformatf("vec%0d", i), tbl[i].rst, tbl[i].cmd, tbl[i].vld,
            tbl[i].hold, tbl[i].eclr, tbl[i].exp);

    // Pop-down sequence: clear, fill to 4, then pop through to underflow.
    apply("seq_clr", 0, NOP, 0, 0, 1, mk_obs(0, K_HOLD, 1, 0, 0, 0));
    for (int n = 1; n <= 4; n++)
      apply($sformatf("seq_fill%0d", n), 0, PSH, 1, 0, 0,
            mk_obs(n, K_PUSH, 0, n == 4, 0, 0));
    for (int n = 3; n >= 0; n--)
      apply($sformatf("seq_pop%0d", n), 0, POP, 1, 0, 0,
            mk_obs(n, K_POP, n == 0, 0, 0, 0));
    apply("seq_pop_unf", 0, POP, 1, 0, 0, mk_obs(0, K_HOLD, 1, 0, 0, 1));

    // Reset mid-sequence with a pending error flag set.
    apply("seq_push", 0, PSH, 1, 0, 0, mk_obs(1, K_PUSH, 0, 0, 0, 1));
    apply("seq_rst", 1, POP, 1, 0, 0, mk_obs(0, K_HOLD, 1, 0, 0, 0));
    apply("seq_after_rst", 0, PSH, 1, 0, 0, mk_obs(1, K_PUSH, 0, 0, 0, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
